// File: rtl/bch_dec_enc_wr_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bch_dec_enc_wr_pipe (with bch_dec_fn_pkg, enc_synd_calc_univ)
// Purpose  : Write-side ECC stage of the DEC BCH memory path. Raw data words
//            enter over a valid/ready slave port, are registered (S1), parity
//            is computed from the S1 register, and the codeword
//            {parity,data} is registered (S2) and offered to the memory write
//            port over a valid/ready master port. Full backpressure, no
//            registered ready, saturating count of handed-off codewords.
// Ports    : clk_i, rst_n_i (async active-low)
//            s_valid_i / s_ready_o / s_data_i[P_D_WIDTH]   raw data in
//            m_valid_o / m_ready_i / m_cw_o[W_CW]          codeword out
//            busy_o      either stage holds a word
//            cnt_o       saturating handed-off codeword count
//            cnt_clr_i   synchronous counter clear (beats increment)
//            inj_req_i / inj_mask_i[W_CW] / inj_done_o
//                        only with BCH_DEC_ENC_WR_PIPE_ERR_INJ_EN defined:
//                        one-shot XOR of a mask into the next S2 load
// Optional : BCH_DEC_ENC_WR_PIPE_ERR_INJ_EN
// Revision : 1.0 - initial release
// ============================================================================

package bch_dec_fn_pkg;

  // Smallest field order m (4..8) whose shortened DEC code of length
  // 2^m-1 holds P_D_WIDTH data bits plus 2m parity bits.
  function automatic int fn_ecc_gf_order(input int d_width);
    int m;
    m = 8;
    for (int k = 8; k >= 4; k--) begin
      if (((1 << k) - 1) >= (d_width + 2 * k)) m = k;
    end
    return m;
  endfunction

  function automatic int fn_ecc_synd_width(input int d_width);
    return 2 * fn_ecc_gf_order(d_width);
  endfunction

  // Generator g(x) = m1(x)*m3(x) of the double-error-correcting BCH code.
  function automatic logic [31:0] fn_ecc_gen_poly(input int d_width);
    case (fn_ecc_gf_order(d_width))
      4:       return 32'h0000_01D1;
      5:       return 32'h0000_0769;
      6:       return 32'h0000_1539;
      7:       return 32'h0000_4377;
      default: return 32'h0001_6F63;
    endcase
  endfunction

endpackage

// Parity (P_SYND_GEN=0): remainder of d(x)*x^W_P mod g(x), so the code
// polynomial is {data,parity}. Syndrome mode (P_SYND_GEN!=0): remainder of
// the input vector itself mod g(x).
module enc_synd_calc_univ
  import bch_dec_fn_pkg::*;
#(
  parameter int P_D_WIDTH  = 16,
  parameter int P_SYND_GEN = 0
) (
  input  logic [P_D_WIDTH-1:0]                    data_i,
  output logic [fn_ecc_synd_width(P_D_WIDTH)-1:0] synd_o
);
  localparam int              W_P      = fn_ecc_synd_width(P_D_WIDTH);
  localparam logic [31:0]     C_GEN    = fn_ecc_gen_poly(P_D_WIDTH);
  localparam logic [W_P-1:0]  C_GEN_LO = C_GEN[W_P-1:0];

  logic [W_P-1:0] w_rem;

  if (P_SYND_GEN == 0) begin : g_enc
    always_comb begin
      w_rem = '0;
      for (int i = P_D_WIDTH - 1; i >= 0; i--) begin
        if (data_i[i] ^ w_rem[W_P-1]) w_rem = {w_rem[W_P-2:0], 1'b0} ^ C_GEN_LO;
        else                          w_rem = {w_rem[W_P-2:0], 1'b0};
      end
    end
  end else begin : g_synd
    always_comb begin
      w_rem = '0;
      for (int i = P_D_WIDTH - 1; i >= 0; i--) begin
        if (w_rem[W_P-1]) w_rem = {w_rem[W_P-2:0], data_i[i]} ^ C_GEN_LO;
        else              w_rem = {w_rem[W_P-2:0], data_i[i]};
      end
    end
  end

  assign synd_o = w_rem;
endmodule

module bch_dec_enc_wr_pipe
  import bch_dec_fn_pkg::*;
#(
  parameter int P_D_WIDTH   = 16,
  parameter int P_CNT_WIDTH = 16
) (
  input  logic                                              clk_i,
  input  logic                                              rst_n_i,
  input  logic                                              s_valid_i,
  output logic                                              s_ready_o,
  input  logic [P_D_WIDTH-1:0]                              s_data_i,
  output logic                                              m_valid_o,
  input  logic                                              m_ready_i,
  output logic [fn_ecc_synd_width(P_D_WIDTH)+P_D_WIDTH-1:0] m_cw_o,
  output logic                                              busy_o,
  output logic [P_CNT_WIDTH-1:0]                            cnt_o,
  input  logic                                              cnt_clr_i
`ifdef BCH_DEC_ENC_WR_PIPE_ERR_INJ_EN
  ,
  input  logic                                              inj_req_i,
  input  logic [fn_ecc_synd_width(P_D_WIDTH)+P_D_WIDTH-1:0] inj_mask_i,
  output logic                                              inj_done_o
`endif
);
  localparam int W_P  = fn_ecc_synd_width(P_D_WIDTH);
  localparam int W_CW = W_P + P_D_WIDTH;

  logic                   v1_q,  v1_d;
  logic                   v2_q,  v2_d;
  logic [P_D_WIDTH-1:0]   d1_q,  d1_d;
  logic [W_CW-1:0]        cw2_q, cw2_d;
  logic [P_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [W_P-1:0]  w_p1;
  logic [W_CW-1:0] w_cw_new;
  logic            w_s1_load;
  logic            w_s2_load;
  logic            w_m_hs;

  // Encoder sees only the S1 register, never s_data_i.
  enc_synd_calc_univ #(
    .P_D_WIDTH  (P_D_WIDTH),
    .P_SYND_GEN (0)
  ) u_enc (
    .data_i (d1_q),
    .synd_o (w_p1)
  );

  assign w_s2_load = v1_q && (!v2_q || m_ready_i);
  assign s_ready_o = !v1_q || !v2_q || m_ready_i;
  assign w_s1_load = s_valid_i && s_ready_o;
  assign w_m_hs    = v2_q && m_ready_i;

`ifdef BCH_DEC_ENC_WR_PIPE_ERR_INJ_EN
  logic            inj_armed_q, inj_armed_d;
  logic [W_CW-1:0] inj_mask_q,  inj_mask_d;
  logic            inj_done_q,  inj_done_d;

  assign w_cw_new = {w_p1, d1_q} ^ (inj_armed_q ? inj_mask_q : '0);

  // A request arriving together with the consuming load re-arms for the
  // following word.
  always_comb begin
    inj_armed_d = inj_armed_q;
    inj_mask_d  = inj_mask_q;
    inj_done_d  = w_s2_load && inj_armed_q;
    if (w_s2_load) inj_armed_d = 1'b0;
    if (inj_req_i) begin
      inj_armed_d = 1'b1;
      inj_mask_d  = inj_mask_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inj_armed_q <= 1'b0;
      inj_mask_q  <= '0;
      inj_done_q  <= 1'b0;
    end else begin
      inj_armed_q <= inj_armed_d;
      inj_mask_q  <= inj_mask_d;
      inj_done_q  <= inj_done_d;
    end
  end

  assign inj_done_o = inj_done_q;
`else
  assign w_cw_new = {w_p1, d1_q};
`endif

  always_comb begin
    v1_d  = v1_q;
    d1_d  = d1_q;
    v2_d  = v2_q;
    cw2_d = cw2_q;
    cnt_d = cnt_q;

    // A load wins over the clear-on-advance so a stage refilled in the same
    // cycle it empties stays valid.
    if (w_s1_load) begin
      v1_d = 1'b1;
      d1_d = s_data_i;
    end else if (w_s2_load) begin
      v1_d = 1'b0;
    end

    if (w_s2_load) begin
      v2_d  = 1'b1;
      cw2_d = w_cw_new;
    end else if (w_m_hs) begin
      v2_d = 1'b0;
    end

    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (w_m_hs && !(&cnt_q)) begin
      cnt_d = cnt_q + {{(P_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      d1_q  <= '0;
      cw2_q <= '0;
      cnt_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      d1_q  <= d1_d;
      cw2_q <= cw2_d;
      cnt_q <= cnt_d;
    end
  end

  assign m_valid_o = v2_q;
  assign m_cw_o    = cw2_q;
  assign busy_o    = v1_q || v2_q;
  assign cnt_o     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bch_dec_enc_wr_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bch_dec_enc_wr_pipe
// Purpose  : Directed self-checking bench for bch_dec_enc_wr_pipe (16-bit
//            data, 10-bit parity, 26-bit codeword). A second instance with a
//            4-bit counter covers counter saturation. Parity is checked by
//            long division of the code polynomial {data,parity} by
//            g(x) = x^10+x^9+x^8+x^6+x^5+x^3+1, which must leave zero.
//            Injection steps exist only with BCH_DEC_ENC_WR_PIPE_ERR_INJ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bch_dec_enc_wr_pipe;
  localparam logic [10:0] C_GEN = 11'h769;

  typedef struct packed {
    logic [15:0] data;
    logic [25:0] mask;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        s_valid;
  logic [15:0] s_data;
  logic        m_ready;
  logic        cnt_clr;
  wire         s_ready, m_valid, busy;
  wire  [25:0] m_cw;
  wire  [15:0] cnt;
  wire         s_ready4, m_valid4, busy4;
  wire  [25:0] m_cw4;
  wire  [3:0]  cnt4;
`ifdef BCH_DEC_ENC_WR_PIPE_ERR_INJ_EN
  logic        inj_req;
  logic [25:0] inj_mask;
  wire         inj_done, inj_done4;
`endif

  always #5 clk = ~clk;

  bch_dec_enc_wr_pipe #(.P_D_WIDTH(16), .P_CNT_WIDTH(16)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_cw_o(m_cw),
    .busy_o(busy), .cnt_o(cnt), .cnt_clr_i(cnt_clr)
`ifdef BCH_DEC_ENC_WR_PIPE_ERR_INJ_EN
    , .inj_req_i(inj_req), .inj_mask_i(inj_mask), .inj_done_o(inj_done)
`endif
  );

  bch_dec_enc_wr_pipe #(.P_D_WIDTH(16), .P_CNT_WIDTH(4)) u_dut_c4 (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .s_valid_i(s_valid), .s_ready_o(s_ready4), .s_data_i(s_data),
    .m_valid_o(m_valid4), .m_ready_i(m_ready), .m_cw_o(m_cw4),
    .busy_o(busy4), .cnt_o(cnt4), .cnt_clr_i(cnt_clr)
`ifdef BCH_DEC_ENC_WR_PIPE_ERR_INJ_EN
    , .inj_req_i(inj_req), .inj_mask_i(inj_mask), .inj_done_o(inj_done4)
`endif
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          n_out = 0;
  int          n_done = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [25:0] inj_next = '0;
  logic [25:0] last_cw = '0;
  logic        prev_stall = 1'b0;
  logic [25:0] prev_cw = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Remainder of {d,p} (as a polynomial, bit index = degree) mod g(x).
  function automatic logic [9:0] poly_rem(input logic [15:0] d, input logic [9:0] p);
    logic [25:0] c;
    c = {d, p};
    for (int i = 25; i >= 10; i--) begin
      if (c[i]) c[i -: 11] = c[i -: 11] ^ C_GEN;
    end
    return c[9:0];
  endfunction

  // Scoreboard and output-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, m_valid}, 32'd1);
        chk("hold_cw", {6'd0, m_cw}, {6'd0, prev_cw});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", exp_q.size(), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cw_data", {16'd0, m_cw[15:0]}, {16'd0, mon_e.data ^ mon_e.mask[15:0]});
          chk("cw_parity", {22'd0, poly_rem(mon_e.data, m_cw[25:16] ^ mon_e.mask[25:16])}, 32'd0);
          last_cw = m_cw;
          n_out++;
        end
      end
`ifdef BCH_DEC_ENC_WR_PIPE_ERR_INJ_EN
      if (inj_done) n_done++;
`endif
      if (s_valid && s_ready) exp_q.push_back({s_data, inj_next});
      prev_stall = m_valid && !m_ready;
      prev_cw    = m_cw;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    bit done;
    int w;
    done    = 1'b0;
    w       = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!done) begin
      @(negedge clk);
      if (s_ready) begin
        done = 1'b1;
      end else if (w > 50) begin
        chk("send_timeout", w, 32'd0);
        done = 1'b1;
      end
      w++;
      tick();
    end
    s_valid = 1'b0;
  endtask

  // Waits until every accepted word has been handed off; returns one edge
  // after the last handshake.
  task automatic drain();
    int w;
    w = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("drain_timeout", exp_q.size(), 32'd0);
    tick();
  endtask

  initial begin
    int   sent;
    int   cyc;
    logic acc;
`ifdef BCH_DEC_ENC_WR_PIPE_ERR_INJ_EN
    logic [9:0] par_clean;
    int         done_before;
    inj_req  = 1'b0;
    inj_mask = '0;
`endif
    rst_n_i = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    cnt_clr = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_cw", {6'd0, m_cw}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", {16'd0, cnt}, 32'd0);
    tick();
    rst_n_i = 1'b1;

    // Single word, latency and codeword
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'hA5C3;
    @(negedge clk);
    chk("a5c3_s_ready", {31'd0, s_ready}, 32'd1);
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    chk("a5c3_lat1_valid", {31'd0, m_valid}, 32'd0);
    chk("a5c3_lat1_busy", {31'd0, busy}, 32'd1);
    tick();
    @(negedge clk);
    chk("a5c3_lat2_valid", {31'd0, m_valid}, 32'd1);
    chk("a5c3_data", {16'd0, m_cw[15:0]}, 32'h0000_A5C3);
    chk("a5c3_parity", {22'd0, poly_rem(16'hA5C3, m_cw[25:16])}, 32'd0);
    chk("a5c3_cnt_pre", {16'd0, cnt}, 32'd0);
    tick();
    @(negedge clk);
    chk("a5c3_valid_after", {31'd0, m_valid}, 32'd0);
    chk("a5c3_cnt", {16'd0, cnt}, 32'd1);
    chk("a5c3_busy_after", {31'd0, busy}, 32'd0);
    tick();

    // Back-to-back stream 0x0000..0x00FF
    for (int i = 0; i < 256; i++) begin
      s_valid = 1'b1;
      s_data  = i[15:0];
      @(negedge clk);
      chk("stream_s_ready", {31'd0, s_ready}, 32'd1);
      if (i >= 2) chk("stream_m_valid", {31'd0, m_valid}, 32'd1);
      tick();
    end
    s_valid = 1'b0;
    drain();
    @(negedge clk);
    chk("stream_cnt", {16'd0, cnt}, 32'd257);
    chk("stream_queue", exp_q.size(), 32'd0);
    tick();

    // Backpressure
    m_ready = 1'b0;
    send(16'h1111);
    send(16'h2222);
    s_valid = 1'b1;
    s_data  = 16'h3333;
    repeat (3) begin
      @(negedge clk);
      chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
      chk("bp_m_cw", {16'd0, m_cw[15:0]}, 32'h0000_1111);
      chk("bp_m_valid", {31'd0, m_valid}, 32'd1);
      tick();
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, s_ready}, 32'd1);
    tick();
    s_valid = 1'b0;
    drain();
    @(negedge clk);
    chk("bp_cnt", {16'd0, cnt}, 32'd260);
    tick();

    // Random traffic, 10k words
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 45000) begin
      m_ready = 1'($urandom_range(0, 1));
      if (!s_valid && $urandom_range(0, 1) == 1) begin
        s_valid = 1'b1;
        s_data  = 16'($urandom);
      end
      @(negedge clk);
      acc = s_valid && s_ready;
      tick();
      if (acc) begin
        sent++;
        s_valid = 1'b0;
      end
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("rnd_sent", sent, 32'd10000);
    chk("rnd_cnt", {16'd0, cnt}, 32'd10260);
    chk("rnd_busy", {31'd0, busy}, 32'd0);
    tick();

    // Reset with both stages full
    m_ready = 1'b0;
    send(16'hDEAD);
    send(16'hBEEF);
    @(negedge clk);
    chk("full_busy", {31'd0, busy}, 32'd1);
    chk("full_s_ready", {31'd0, s_ready}, 32'd0);
    #2 rst_n_i = 1'b0;
    #1;
    chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_cnt", {16'd0, cnt}, 32'd0);
    chk("midrst_m_cw", {6'd0, m_cw}, 32'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n_i = 1'b1;
    m_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("postrst_m_valid", {31'd0, m_valid}, 32'd0);
      tick();
    end

    // Counter saturation (4-bit instance) and clear priority
    for (int i = 0; i < 15; i++) send(16'h0100 + 16'(i));
    drain();
    @(negedge clk);
    chk("sat_cnt4_15", {28'd0, cnt4}, 32'd15);
    chk("sat_cnt_15", {16'd0, cnt}, 32'd15);
    tick();
    send(16'h0F0F);
    drain();
    @(negedge clk);
    chk("sat_cnt4_hold", {28'd0, cnt4}, 32'd15);
    chk("sat_cnt_16", {16'd0, cnt}, 32'd16);
    tick();
    send(16'h1234);
    tick();
    cnt_clr = 1'b1;
    @(negedge clk);
    chk("clr_coincident_hs", {31'd0, m_valid && m_ready}, 32'd1);
    tick();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_cnt", {16'd0, cnt}, 32'd0);
    chk("clr_cnt4", {28'd0, cnt4}, 32'd0);
    chk("clr_queue", exp_q.size(), 32'd0);
    tick();

`ifdef BCH_DEC_ENC_WR_PIPE_ERR_INJ_EN
    // Error injection: bits 0 and 5 flipped in the data field
    send(16'h00FF);
    drain();
    par_clean = last_cw[25:16];
    inj_mask  = 26'h000_0021;
    inj_req   = 1'b1;
    tick();
    inj_req     = 1'b0;
    done_before = n_done;
    inj_next    = 26'h000_0021;
    send(16'h00FF);
    inj_next = '0;
    drain();
    tick();
    chk("inj_data", {16'd0, last_cw[15:0]}, 32'h0000_00DE);
    chk("inj_parity", {22'd0, last_cw[25:16]}, {22'd0, par_clean});
    chk("inj_done_pulses", n_done - done_before, 32'd1);
    send(16'h00FF);
    drain();
    chk("inj_after_data", {16'd0, last_cw[15:0]}, 32'h0000_00FF);
    chk("inj_after_parity", {22'd0, last_cw[25:16]}, {22'd0, par_clean});
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
